regfile_dump: RTL
=================

Name: regfile_dump

Overview:
- Sequential read-side initiator for the 32x32 register file.
- On a Start pulse it walks the register file's combinational read port from FIRST_REG to LAST_REG.
- Each word is captured and streamed out over a valid/ready handshake, with a running XOR checksum.
- Sits beside the processor datapath for debug/trace. It drives one register-file read address, muxed in by the top level while the core is halted.

Parameters:
- DATA_WIDTH, 32, width of register words and checksum.
- ADDR_WIDTH, 5, width of register addresses.
- FIRST_REG, 0, first address dumped.
- LAST_REG, 31, last address dumped. FIRST_REG <= LAST_REG <= 2**ADDR_WIDTH-1 is required; violation is a static error.

Ports:
- Clock  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin dump; sampled only in IDLE.
- Abort  in  1  synchronous abort; returns to IDLE.
- Busy  out  1  high in READ/HOLD.
- Done  out  1  one-cycle pulse after the last word is accepted.
- DumpAddr  out  ADDR_WIDTH  register-file read address.
- DumpData  in  DATA_WIDTH  register-file read data for DumpAddr, valid in the same cycle (combinational read).
- OutValid  out  1  output word valid.
- OutReady  in  1  consumer accepts the word.
- OutAddr  out  ADDR_WIDTH  address of OutData.
- OutData  out  DATA_WIDTH  captured register word.
- Checksum  out  DATA_WIDTH  XOR of all words captured in the current/last dump.
- ChecksumValid  out  1  Checksum final.

Behaviour:
- Reset (async assert, any state): state=IDLE; all outputs 0 (Busy, Done, DumpAddr, OutValid, OutAddr, OutData, Checksum, ChecksumValid).
- IDLE:
  - Start=1 -> DumpAddr<=FIRST_REG, Checksum<=0, ChecksumValid<=0, go READ.
  - Abort in IDLE has no effect.
- READ (1 cycle):
  - OutData<=DumpData, OutAddr<=DumpAddr, OutValid<=1, Checksum<=Checksum^DumpData.
  - Go HOLD.
- HOLD:
  - OutValid=1; OutData/OutAddr held stable until OutReady=1 (no changes while stalled).
  - On OutReady=1: OutValid<=0.
  - If OutAddr==LAST_REG: go DONE.
  - Else: DumpAddr<=DumpAddr+1, go READ.
- DONE (1 cycle):
  - Done=1, ChecksumValid<=1, go IDLE.
  - ChecksumValid and Checksum held until next accepted Start.
- Throughput: one word per 2 cycles with OutReady tied high. Start-to-first-OutValid latency is 2 cycles.
- Total cycles from Start to Done for N words with OutReady tied high is 2N+1. The default is N=32, giving 65 cycles.
- Abort=1 in READ/HOLD/DONE:
  - Next state IDLE; OutValid<=0, Done stays 0, ChecksumValid<=0.
  - Checksum keeps its partial value. DumpAddr holds.
  - Abort has priority over OutReady in the same cycle; the word is not counted as accepted.
- Start while Busy: ignored.
- Start and Abort together in IDLE: Start wins.
- Address 0: the register file returns 0, so the dump emits 0 and contributes nothing to the checksum. No special-casing.
- Wrap-around: DumpAddr never increments past LAST_REG; LAST_REG = 2**ADDR_WIDTH-1 must not wrap to 0.
- Reset mid-dump: immediate return to IDLE with all outputs 0. No Done pulse.

Decomposition:
- Shared package: state enum (IDLE, READ, HOLD, DONE), DATA_WIDTH/ADDR_WIDTH constants shared with the register file.
- No sub-module needed. Optionally split the output holding register into regfile_dump_outreg; default is a single module.

Test Plan:
- Preload regs r1..r31 = 0x100+i (r0=0), OutReady=1, pulse Start -> 32 words: OutAddr 0..31, OutData 0,0x101..0x11F. Done at cycle 65 after Start. Checksum = XOR of 0x101..0x11F, ChecksumValid=1.
- Backpressure: OutReady low for 5 cycles at word r7 -> OutValid=1, OutAddr=7, OutData=0x107 stable all 5 cycles, DumpAddr stays 7. Dump resumes with r8, final checksum unchanged.
- Abort on the cycle OutReady accepts r10 -> no further OutValid, Done never pulses, ChecksumValid=0, Busy=0 next cycle. New Start restarts at r0 with Checksum cleared.
- Reset asserted asynchronously mid-HOLD (between clock edges) at r20 -> all outputs 0 immediately. Start pulses while Busy are ignored (count of words stays 32 in a separate run).
- FIRST_REG=30, LAST_REG=31 -> exactly 2 words (30, 31), Done 5 cycles after Start, no wrap to 0.
- Start and Abort asserted together in IDLE -> dump starts (Busy=1 next cycle).

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine and the register file it reads.
package regfile_dump_pkg;

   localparam int unsigned RF_DATA_WIDTH = 32;
   localparam int unsigned RF_ADDR_WIDTH = 5;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      HOLD,
      DONE
   } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Sequential read-side initiator: walks the register file read port and streams
// each word out over valid/ready while accumulating an XOR checksum.
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int unsigned FIRST_REG  = 0,
   parameter int unsigned LAST_REG   = 31
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Abort,
   output logic                  Busy,
   output logic                  Done,
   output logic [ADDR_WIDTH-1:0] DumpAddr,
   input  logic [DATA_WIDTH-1:0] DumpData,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic [ADDR_WIDTH-1:0] OutAddr,
   output logic [DATA_WIDTH-1:0] OutData,
   output logic [DATA_WIDTH-1:0] Checksum,
   output logic                  ChecksumValid
);

   if ((FIRST_REG > LAST_REG) || (LAST_REG > (2**ADDR_WIDTH) - 1)) begin : g_bad_range
      $error("regfile_dump: require FIRST_REG <= LAST_REG <= 2**ADDR_WIDTH-1");
   end

   localparam logic [ADDR_WIDTH-1:0] FIRST_A = ADDR_WIDTH'(FIRST_REG);
   localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(LAST_REG);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [DATA_WIDTH-1:0]   cksum_q, cksum_d;
   logic                    cksum_valid_q, cksum_valid_d;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         out_valid_q   <= 1'b0;
         out_addr_q    <= '0;
         out_data_q    <= '0;
         cksum_q       <= '0;
         cksum_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         out_valid_q   <= out_valid_d;
         out_addr_q    <= out_addr_d;
         out_data_q    <= out_data_d;
         cksum_q       <= cksum_d;
         cksum_valid_q <= cksum_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      out_valid_d   = out_valid_q;
      out_addr_d    = out_addr_q;
      out_data_d    = out_data_q;
      cksum_d       = cksum_q;
      cksum_valid_d = cksum_valid_q;

      unique case (state_q)
         IDLE: begin
            // Start outranks Abort here; Abort alone is a no-op in IDLE
            if (Start) begin
               addr_d        = FIRST_A;
               cksum_d       = '0;
               cksum_valid_d = 1'b0;
               state_d       = READ;
            end
         end
         READ: begin
            if (Abort) begin
               out_valid_d   = 1'b0;
               cksum_valid_d = 1'b0;
               state_d       = IDLE;
            end else begin
               out_data_d  = DumpData;
               out_addr_d  = addr_q;
               out_valid_d = 1'b1;
               cksum_d     = cksum_q ^ DumpData;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            // Abort beats OutReady: the word in flight is dropped, not accepted
            if (Abort) begin
               out_valid_d   = 1'b0;
               cksum_valid_d = 1'b0;
               state_d       = IDLE;
            end else if (OutReady) begin
               out_valid_d = 1'b0;
               if (out_addr_q == LAST_A) begin
                  state_d = DONE;
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  state_d = READ;
               end
            end
         end
         DONE: begin
            if (Abort) begin
               out_valid_d   = 1'b0;
               cksum_valid_d = 1'b0;
            end else begin
               cksum_valid_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign Busy          = (state_q == READ) || (state_q == HOLD);
   assign Done          = (state_q == DONE) && !Abort;
   assign DumpAddr      = addr_q;
   assign OutValid      = out_valid_q;
   assign OutAddr       = out_addr_q;
   assign OutData       = out_data_q;
   assign Checksum      = cksum_q;
   assign ChecksumValid = cksum_valid_q;

endmodule
